id_alu_issue: RTL and testbench

//  Decode stage back end: decodes the RV32I instruction in ID, selects ALU operands, and registers them in the ID/EX pipeline register.

---
 rtl/alu_pkg.sv | 70 +++++++
 rtl/imm_gen.sv | 19 +
 rtl/id_alu_issue.sv | 184 ++++++++++++++++++
 tb/tb_id_alu_issue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the decode/issue stage: ALU opcodes, RV32I major
// opcodes and the layout of the ID/EX pipeline register.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic            valid;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            branch;
    logic [2:0]      funct3;
    logic            mem_rd;
    logic            mem_wr;
    logic            jump;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } id_ex_t;

  // A bubble is all zeros; ALU_ADD is deliberately encoded as 0 so this holds.
  localparam id_ex_t ID_EX_BUBBLE = '0;

  // Base-encoding funct3 to ALU op, shared by OP and OP-IMM.
  function automatic logic [3:0] op_from_funct3(input logic [2:0] f3);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'd0: op = ALU_ADD;
      3'd1: op = ALU_SLL;
      3'd2: op = ALU_SLT;
      3'd3: op = ALU_SLTU;
      3'd4: op = ALU_XOR;
      3'd5: op = ALU_SRL;
      3'd6: op = ALU_OR;
      3'd7: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for every RV32I format; all results are sign-extended.
module imm_gen
  import alu_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] s_imm,
  output logic [XLEN-1:0] b_imm,
  output logic [XLEN-1:0] u_imm,
  output logic [XLEN-1:0] j_imm
);

  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/id_alu_issue.sv
// Decode stage back end: decodes the ID instruction, picks ALU operands and
// control, and registers them into the ID/EX pipeline register.
module id_alu_issue
  import alu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic [2:0]      ex_funct3,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_jump,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);

  localparam id_ex_t RESET_VAL = '{pc: RESET_PC, default: '0};

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [XLEN-1:0] shamt;
  logic            unused_imm;
  logic            wants_write;
  logic            bad;
  id_ex_t          dec;
  id_ex_t          ex_q;

  assign opcode   = id_instr[6:0];
  assign rd       = id_instr[11:7];
  assign funct3   = id_instr[14:12];
  assign rs1_addr = id_instr[19:15];
  assign rs2_addr = id_instr[24:20];
  assign funct7   = id_instr[31:25];
  assign shamt    = {27'b0, id_instr[24:20]};

  imm_gen u_imm_gen (
    .instr (id_instr),
    .i_imm (i_imm),
    .s_imm (s_imm),
    .b_imm (b_imm),
    .u_imm (u_imm),
    .j_imm (j_imm)
  );

  // Branch and jump targets are formed in EX, so B/J immediates are not needed here.
  assign unused_imm = ^{b_imm, j_imm};

  always_comb begin
    dec          = ID_EX_BUBBLE;
    dec.valid    = 1'b1;
    dec.alu_op   = ALU_ADD;
    dec.pc       = id_pc;
    dec.rd       = rd;
    dec.funct3   = funct3;
    dec.rs2_data = rs2_data;
    wants_write  = 1'b0;
    bad          = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.a       = rs1_data;
        dec.b       = rs2_data;
        wants_write = 1'b1;
        if (funct7 == F7_BASE)                    dec.alu_op = op_from_funct3(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'd0) dec.alu_op = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'd5) dec.alu_op = ALU_SRA;
        else                                      bad = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.a       = rs1_data;
        dec.b       = i_imm;
        wants_write = 1'b1;
        dec.alu_op  = op_from_funct3(funct3);
        if (funct3 == 3'd1) begin
          dec.b = shamt;
          bad   = (funct7 != F7_BASE);
        end else if (funct3 == 3'd5) begin
          dec.b      = shamt;
          dec.alu_op = id_instr[30] ? ALU_SRA : ALU_SRL;
          bad        = (funct7 != F7_BASE) && (funct7 != F7_ALT);
        end
      end
      OPC_LUI: begin
        dec.alu_op  = ALU_LUI;
        dec.b       = u_imm;
        wants_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a       = id_pc;
        dec.b       = u_imm;
        wants_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.a       = id_pc;
        dec.b       = 32'd4;
        dec.jump    = 1'b1;
        wants_write = 1'b1;
        bad         = (opcode == OPC_JALR) && (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        dec.a      = rs1_data;
        dec.b      = rs2_data;
        dec.branch = 1'b1;
        case (funct3[2:1])
          2'b00:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.a       = rs1_data;
        dec.b       = i_imm;
        dec.mem_rd  = 1'b1;
        wants_write = 1'b1;
        bad         = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        dec.a      = rs1_data;
        dec.b      = s_imm;
        dec.mem_wr = 1'b1;
        bad        = (funct3 > 3'd2);
      end
      default: bad = 1'b1;
    endcase
    // An illegal instruction keeps its slot but must not cause any side effect.
    if (bad) begin
      dec.alu_op  = ALU_ADD;
      dec.a       = '0;
      dec.b       = '0;
      dec.branch  = 1'b0;
      dec.jump    = 1'b0;
      dec.mem_rd  = 1'b0;
      dec.mem_wr  = 1'b0;
      dec.illegal = 1'b1;
      wants_write = 1'b0;
    end
    dec.reg_write = wants_write && (rd != 5'd0);
  end

  // Flush beats stall; an empty ID slot turns into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ex_q <= RESET_VAL;
    else if (flush)      ex_q <= ID_EX_BUBBLE;
    else if (!stall)     ex_q <= id_valid ? dec : ID_EX_BUBBLE;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_a         = ex_q.a;
  assign ex_b         = ex_q.b;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_branch    = ex_q.branch;
  assign ex_funct3    = ex_q.funct3;
  assign ex_mem_rd    = ex_q.mem_rd;
  assign ex_mem_wr    = ex_q.mem_wr;
  assign ex_jump      = ex_q.jump;
  assign ex_pc        = ex_q.pc;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_alu_issue.sv
// Directed and random checks of id_alu_issue against an instruction-level
// reference model of what should land in the EX slot.
module tb_id_alu_issue;

  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        stall, flush;
  logic        ex_valid, ex_reg_write, ex_branch, ex_mem_rd, ex_mem_wr, ex_jump, ex_illegal;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_a, ex_b, ex_rs2_data, ex_pc;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;

  id_alu_issue #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_jump(ex_jump), .ex_pc(ex_pc),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, wr, br, mrd, mwr, jmp, ill;
    logic [3:0]  op;
    logic [31:0] a, b, sd, pc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    bit          cmp_path, cmp_f3, cmp_sd;
  } exp_t;

  exp_t cur;
  int   total = 0;
  int   bad = 0;

  function automatic exp_t empty_slot(input logic [31:0] pc);
    exp_t e;
    e.valid = 0; e.wr = 0; e.br = 0; e.mrd = 0; e.mwr = 0; e.jmp = 0; e.ill = 0;
    e.op = 0; e.a = 0; e.b = 0; e.sd = 0; e.pc = pc; e.rd = 0; e.f3 = 0;
    e.cmp_path = 1; e.cmp_f3 = 1; e.cmp_sd = 1;
    return e;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, pc, r1, r2);
    exp_t e;
    int   alu_for_f3 [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    logic signed [31:0] si;
    logic [31:0] imm_i, imm_s;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    bit          legal, writes;
    si = ins;
    imm_i = 32'(si >>> 20);
    imm_s = {imm_i[31:5], ins[11:7]};
    opc = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12];
    e = empty_slot(pc);
    e.valid = 1; e.rd = ins[11:7]; e.f3 = f3; e.sd = r2;
    e.cmp_f3 = 0; e.cmp_sd = 0;
    legal = 1; writes = 0;
    case (opc)
      7'h33: begin
        e.a = r1; e.b = r2; writes = 1;
        if (f7 == 0) e.op = 4'(alu_for_f3[f3]);
        else if (f7 == 7'h20 && f3 == 0) e.op = 1;
        else if (f7 == 7'h20 && f3 == 5) e.op = 7;
        else legal = 0;
      end
      7'h13: begin
        e.a = r1; writes = 1;
        if (f3 == 1 || f3 == 5) begin
          e.b = {27'b0, ins[24:20]};
          legal = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
          e.op = (f3 == 1) ? 4'd5 : (ins[30] ? 4'd7 : 4'd6);
        end else begin
          e.b = imm_i; e.op = 4'(alu_for_f3[f3]);
        end
      end
      7'h37: begin e.op = 10; e.a = 0; e.b = ins & 32'hFFFF_F000; writes = 1; end
      7'h17: begin e.a = pc; e.b = ins & 32'hFFFF_F000; writes = 1; end
      7'h6F: begin e.a = pc; e.b = 4; e.jmp = 1; writes = 1; end
      7'h67: begin e.a = pc; e.b = 4; e.jmp = 1; writes = 1; legal = (f3 == 0); end
      7'h63: begin
        e.a = r1; e.b = r2; e.br = 1; e.cmp_f3 = 1;
        e.op = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd8 : 4'd9;
        legal = !(f3 == 2 || f3 == 3);
      end
      7'h03: begin
        e.a = r1; e.b = imm_i; e.mrd = 1; writes = 1; e.cmp_f3 = 1;
        legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'h23: begin
        e.a = r1; e.b = imm_s; e.mwr = 1; e.cmp_f3 = 1; e.cmp_sd = 1;
        legal = (f3 < 3);
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      e.ill = 1; e.op = 0; e.br = 0; e.jmp = 0; e.mrd = 0; e.mwr = 0; writes = 0;
      e.cmp_path = 0; e.cmp_f3 = 0; e.cmp_sd = 0;
    end
    e.wr = writes && (ins[11:7] != 0);
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  opcs [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h00};
    int          k;
    ins = $urandom;
    k = $urandom_range(0, 9);
    ins[6:0] = (k == 9) ? 7'($urandom) : opcs[k];
    if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ins[31:25] = 7'($urandom);
      endcase
    end
    return ins;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_slot(input string tag);
    check_output({tag, ".valid"},   32'(ex_valid),     32'(cur.valid));
    check_output({tag, ".illegal"}, 32'(ex_illegal),   32'(cur.ill));
    check_output({tag, ".alu_op"},  32'(ex_alu_op),    32'(cur.op));
    check_output({tag, ".reg_wr"},  32'(ex_reg_write), 32'(cur.wr));
    check_output({tag, ".branch"},  32'(ex_branch),    32'(cur.br));
    check_output({tag, ".mem_rd"},  32'(ex_mem_rd),    32'(cur.mrd));
    check_output({tag, ".mem_wr"},  32'(ex_mem_wr),    32'(cur.mwr));
    check_output({tag, ".jump"},    32'(ex_jump),      32'(cur.jmp));
    check_output({tag, ".pc"},      ex_pc,             cur.pc);
    if (cur.cmp_path) begin
      check_output({tag, ".a"},  ex_a,         cur.a);
      check_output({tag, ".b"},  ex_b,         cur.b);
      check_output({tag, ".rd"}, 32'(ex_rd),   32'(cur.rd));
    end
    if (cur.cmp_f3) check_output({tag, ".funct3"}, 32'(ex_funct3), 32'(cur.f3));
    if (cur.cmp_sd) check_output({tag, ".rs2_data"}, ex_rs2_data, cur.sd);
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] ins, pc, r1, r2,
                                input logic st, fl, input string tag);
    @(negedge clk);
    id_valid = v; id_instr = ins; id_pc = pc; rs1_data = r1; rs2_data = r2;
    stall = st; flush = fl;
    #1;
    check_output({tag, ".rs1_addr"}, 32'(rs1_addr), 32'(ins[19:15]));
    check_output({tag, ".rs2_addr"}, 32'(rs2_addr), 32'(ins[24:20]));
    @(posedge clk);
    if (fl)       cur = empty_slot(32'h0);
    else if (!st) cur = v ? ref_decode(ins, pc, r1, r2) : empty_slot(32'h0);
    #1;
    check_slot(tag);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_instr = 0; id_pc = 0; rs1_data = 0; rs2_data = 0;
    stall = 0; flush = 0;
    cur = empty_slot(RST_PC);
    #12;
    check_slot("reset");
    @(negedge clk) rst = 1'b0;

    apply_stimulus(1, enc_i(12'hFFF, 5'd1, 3'd0, 5'd5, 7'h13), 32'h10, 32'd7, 32'd99, 0, 0, "addi");
    check_output("addi.b_const", ex_b, 32'hFFFF_FFFF);
    apply_stimulus(1, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h14, 32'd50, 32'd8, 0, 0, "sub");
    check_output("sub.op_const", 32'(ex_alu_op), 32'd1);
    apply_stimulus(1, enc_i({7'h20, 5'd4}, 5'd2, 3'd5, 5'd3, 7'h13), 32'h18, 32'hF000_0000, 32'd1, 0, 0, "srai");
    check_output("srai.op_const", 32'(ex_alu_op), 32'd7);
    apply_stimulus(1, enc_i({7'h21, 5'd4}, 5'd2, 3'd5, 5'd3, 7'h13), 32'h1C, 32'd1, 32'd2, 0, 0, "srli_bad");
    check_output("srli_bad.ill_const", 32'(ex_illegal), 32'd1);
    apply_stimulus(1, {20'hABCDE, 5'd1, 7'h37}, 32'h20, 32'd3, 32'd4, 0, 0, "lui");
    check_output("lui.b_const", ex_b, 32'hABCD_E000);
    apply_stimulus(1, {20'h00001, 5'd6, 7'h17}, 32'h100, 32'd3, 32'd4, 0, 0, "auipc");
    check_output("auipc.b_const", ex_b, 32'h0000_1000);
    apply_stimulus(1, enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd8, 7'h63), 32'h104, 32'd5, 32'd6, 0, 0, "bltu");
    check_output("bltu.op_const", 32'(ex_alu_op), 32'd9);
    apply_stimulus(1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33), 32'h108, 32'd5, 32'd6, 0, 0, "add_x0");
    check_output("add_x0.wr_const", 32'(ex_reg_write), 32'd0);
    apply_stimulus(1, 32'h0080_00EF, 32'h10C, 32'd5, 32'd6, 0, 0, "jal");
    apply_stimulus(1, enc_r(7'h01, 5'd2, 5'd1, 3'd2, 5'd4, 7'h23), 32'h110, 32'd5, 32'hCAFE, 0, 0, "sw");
    for (int i = 0; i < 3; i++)
      apply_stimulus(1, rand_instr(), $urandom, $urandom, $urandom, 1, 0, "stall");
    check_output("stall.pc_const", ex_pc, 32'h110);
    apply_stimulus(1, enc_i(12'h005, 5'd1, 3'd0, 5'd2, 7'h13), 32'h114, 32'd1, 32'd1, 1, 1, "stall_flush");
    apply_stimulus(0, enc_i(12'h005, 5'd1, 3'd0, 5'd2, 7'h13), 32'h118, 32'd1, 32'd1, 0, 0, "no_valid");
    apply_stimulus(1, 32'h0000_007F, 32'h11C, 32'd1, 32'd1, 0, 0, "opc_7f");
    check_output("opc_7f.valid_const", 32'(ex_valid), 32'd1);

    apply_stimulus(1, enc_i(12'h001, 5'd1, 3'd0, 5'd2, 7'h13), 32'h120, 32'd1, 32'd1, 0, 0, "pre_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    cur = empty_slot(RST_PC);
    #1;
    check_slot("mid_rst");
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 300; i++)
      apply_stimulus($urandom_range(0, 7) != 0, rand_instr(), $urandom, $urandom, $urandom,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
